his_readout: RTL and testbench

HIS_READOUT -- requirements
Module: his_readout

---
 rtl/his_readout.sv | 160 ++++++++++++++++
 tb/tb_his_readout.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/his_readout.sv
// Histogram readout: sweeps bins 1..NB through a 1-cycle-latency memory, streams
// each count out over a valid/ready handshake and reports the first maximum bin.
module his_readout #(
  parameter int NB          = 16,
  parameter int CW          = 8,
  parameter int CLR_ON_READ = 1,
  localparam int BW         = $clog2(NB + 1)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          hisNum,
  output logic [NB-1:0] rdAddr,
  input  logic [CW-1:0] rdData,
  output logic          clrEn,
  output logic          outValid,
  input  logic          outReady,
  output logic [BW-1:0] outBin,
  output logic [CW-1:0] outCount,
  output logic          outLast,
  output logic          outHis,
  output logic          busy,
  output logic [BW-1:0] peakBin,
  output logic [CW-1:0] peakCount,
  output logic          peakValid
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_SEND, S_DONE} state_t;

  localparam logic [BW-1:0] LAST_BIN = BW'(NB);
  localparam logic          CLR_BIT  = (CLR_ON_READ != 0);

  state_t          state_q, state_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic [NB-1:0]   rd_addr_q, rd_addr_d;
  logic            clr_en_q, clr_en_d;
  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   out_count_q, out_count_d;
  logic            out_last_q, out_last_d;
  logic            out_his_q, out_his_d;
  logic            busy_q, busy_d;
  logic [BW-1:0]   peak_bin_q, peak_bin_d;
  logic [CW-1:0]   peak_count_q, peak_count_d;
  logic            peak_valid_q, peak_valid_d;
  logic [BW-1:0]   bin_nxt;

  // Bin b (1-based) maps to rdAddr bit b-1.
  function automatic logic [NB-1:0] onehot(input logic [BW-1:0] b);
    return NB'(1) << (b - BW'(1));
  endfunction

  assign bin_nxt = bin_q + BW'(1);

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    rd_addr_d    = rd_addr_q;
    clr_en_d     = clr_en_q;
    out_valid_d  = out_valid_q;
    out_count_d  = out_count_q;
    out_last_d   = out_last_q;
    out_his_d    = out_his_q;
    busy_d       = busy_q;
    peak_bin_d   = peak_bin_q;
    peak_count_d = peak_count_q;
    peak_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_ADDR;
          out_his_d    = hisNum;
          bin_d        = BW'(1);
          peak_bin_d   = '0;
          peak_count_d = '0;
          rd_addr_d    = onehot(BW'(1));
          busy_d       = 1'b1;
        end
      end
      S_ADDR: begin
        state_d  = S_WAIT;
        clr_en_d = CLR_BIT;
      end
      S_WAIT: begin
        state_d     = S_SEND;
        out_count_d = rdData;
        clr_en_d    = 1'b0;
        rd_addr_d   = '0;
        out_valid_d = 1'b1;
        out_last_d  = (bin_q == LAST_BIN);
      end
      S_SEND: begin
        if (outReady) begin
          // Strict compare keeps the lowest bin on ties and ignores empty bins.
          if (out_count_q > peak_count_q) begin
            peak_count_d = out_count_q;
            peak_bin_d   = bin_q;
          end
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (bin_q == LAST_BIN) begin
            state_d      = S_DONE;
            peak_valid_d = 1'b1;
          end else begin
            state_d   = S_ADDR;
            bin_d     = bin_nxt;
            rd_addr_d = onehot(bin_nxt);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= S_IDLE;
      bin_q        <= '0;
      rd_addr_q    <= '0;
      clr_en_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_count_q  <= '0;
      out_last_q   <= 1'b0;
      out_his_q    <= 1'b0;
      busy_q       <= 1'b0;
      peak_bin_q   <= '0;
      peak_count_q <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      rd_addr_q    <= rd_addr_d;
      clr_en_q     <= clr_en_d;
      out_valid_q  <= out_valid_d;
      out_count_q  <= out_count_d;
      out_last_q   <= out_last_d;
      out_his_q    <= out_his_d;
      busy_q       <= busy_d;
      peak_bin_q   <= peak_bin_d;
      peak_count_q <= peak_count_d;
      peak_valid_q <= peak_valid_d;
    end
  end

  assign rdAddr    = rd_addr_q;
  assign clrEn     = clr_en_q;
  assign outValid  = out_valid_q;
  assign outBin    = bin_q;
  assign outCount  = out_count_q;
  assign outLast   = out_last_q;
  assign outHis    = out_his_q;
  assign busy      = busy_q;
  assign peakBin   = peak_bin_q;
  assign peakCount = peak_count_q;
  assign peakValid = peak_valid_q;

endmodule

// File: tb/tb_his_readout.sv
// Randomized scoreboard bench for his_readout with an 8-bin behavioural memory.
module tb_his_readout;
  localparam int NB = 8;
  localparam int CW = 8;
  localparam int BW = $clog2(NB + 1);

  logic          clk = 0;
  logic          res;
  logic          start;
  logic          hisNum;
  logic [NB-1:0] rdAddr;
  logic [CW-1:0] rdData = '0;
  logic          clrEn;
  logic          outValid;
  logic          outReady = 1'b1;
  logic [BW-1:0] outBin;
  logic [CW-1:0] outCount;
  logic          outLast;
  logic          outHis;
  logic          busy;
  logic [BW-1:0] peakBin;
  logic [CW-1:0] peakCount;
  logic          peakValid;

  his_readout #(.NB(NB), .CW(CW), .CLR_ON_READ(1)) dut (
    .clk(clk), .res(res), .start(start), .hisNum(hisNum),
    .rdAddr(rdAddr), .rdData(rdData), .clrEn(clrEn),
    .outValid(outValid), .outReady(outReady), .outBin(outBin),
    .outCount(outCount), .outLast(outLast), .outHis(outHis), .busy(busy),
    .peakBin(peakBin), .peakCount(peakCount), .peakValid(peakValid)
  );

  always #5 clk = ~clk;

  typedef struct {int bin; int cnt; bit last; bit his;} beat_t;
  typedef struct {int bin; int cnt; bit his;} peak_t;

  beat_t bq[$];
  peak_t pq[$];
  int    nchecks = 0;
  int    nerrs   = 0;
  int    cyc     = 0;
  int    k_edge  = 0;
  bit    lat_on  = 0;
  int    rdy_mode = 0;
  int    clr_total = 0;
  int    stall_total = 0;
  int    hist [1:NB];

  task automatic chk(input string name, input longint act, input longint exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data one cycle after address.
  always @(posedge clk) begin
    int v;
    v = 0;
    for (int i = 0; i < NB; i++) if (rdAddr[i]) v = hist[i+1];
    rdData <= CW'(v);
  end

  // Ready driver: 0 = always ready, 1 = random, 2 = stall bin 2 for 5 cycles.
  always @(posedge clk) begin
    int stall_n;
    #1;
    if (rdy_mode != 2) stall_n = 0;
    case (rdy_mode)
      1: outReady = 1'($urandom_range(0, 1));
      2: begin
        if (outValid && outBin == BW'(2) && stall_n < 5) begin
          outReady = 1'b0;
          stall_n++;
        end else outReady = 1'b1;
      end
      default: outReady = 1'b1;
    endcase
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    bit stall_prev;
    logic [BW-1:0] s_bin;
    logic [CW-1:0] s_cnt;
    logic          s_last;
    beat_t b;
    peak_t p;
    if (!res) stall_prev = 0;
    else begin
      if (clrEn) begin
        clr_total++;
        chk("clr_with_addr", (rdAddr != 0), 1);
      end
      if (outValid) begin
        chk("no_addr_in_send", rdAddr, 0);
        if (stall_prev) begin
          chk("stable_bin", outBin, s_bin);
          chk("stable_cnt", outCount, s_cnt);
          chk("stable_last", outLast, s_last);
        end
        if (outReady) begin
          stall_prev = 0;
          if (bq.size() == 0) chk("beat_unexpected", outBin, 0);
          else begin
            b = bq.pop_front();
            chk("beat_bin", outBin, b.bin);
            chk("beat_cnt", outCount, b.cnt);
            chk("beat_last", outLast, b.last);
            chk("beat_his", outHis, b.his);
            if (lat_on) chk("beat_latency", cyc, k_edge + 3*b.bin - 1);
          end
        end else begin
          stall_prev = 1;
          stall_total++;
          s_bin = outBin; s_cnt = outCount; s_last = outLast;
        end
      end
      if (peakValid) begin
        if (pq.size() == 0) chk("peak_unexpected", peakBin, 0);
        else begin
          p = pq.pop_front();
          chk("peak_bin", peakBin, p.bin);
          chk("peak_cnt", peakCount, p.cnt);
          chk("peak_his", outHis, p.his);
          chk("peak_busy", busy, 1);
          if (lat_on) chk("peak_latency", cyc, k_edge + 3*NB);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdAddr"}, rdAddr, 0);
    chk({tag, "_clrEn"}, clrEn, 0);
    chk({tag, "_outValid"}, outValid, 0);
    chk({tag, "_outBin"}, outBin, 0);
    chk({tag, "_outCount"}, outCount, 0);
    chk({tag, "_outLast"}, outLast, 0);
    chk({tag, "_outHis"}, outHis, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_peakBin"}, peakBin, 0);
    chk({tag, "_peakCount"}, peakCount, 0);
    chk({tag, "_peakValid"}, peakValid, 0);
  endtask

  // Reference: stream every bin in order; peak is the first bin holding the
  // largest nonzero count, or bin 0 when the histogram is empty.
  task automatic expect_sweep(input int vals [1:NB], input bit his, output peak_t p);
    beat_t b;
    p.bin = 0; p.cnt = 0; p.his = his;
    for (int i = 1; i <= NB; i++) begin
      b.bin = i; b.cnt = vals[i]; b.last = (i == NB); b.his = his;
      bq.push_back(b);
      if (vals[i] > p.cnt) begin p.cnt = vals[i]; p.bin = i; end
    end
    pq.push_back(p);
  endtask

  task automatic pulse_start(input bit his);
    @(posedge clk); #1;
    hisNum = his; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k_edge = cyc;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    chk("sweep_done_in_time", busy, 0);
  endtask

  task automatic run_sweep(input int vals [1:NB], input bit his, input int mode, input bit poke);
    peak_t p;
    int clr0;
    hist = vals;
    rdy_mode = mode;
    lat_on = (mode == 0);
    expect_sweep(vals, his, p);
    clr0 = clr_total;
    pulse_start(his);
    chk("start_accept", busy, 1);
    if (poke) begin
      repeat (4) @(posedge clk);
      #1 hisNum = ~his; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_beats_empty", bq.size(), 0);
    chk("queue_peak_empty", pq.size(), 0);
    chk("clr_pulses", clr_total - clr0, NB);
    chk("hold_peakBin", peakBin, p.bin);
    chk("hold_peakCount", peakCount, p.cnt);
    chk("hold_outHis", outHis, his);
    chk("idle_outValid", outValid, 0);
    rdy_mode = 0;
  endtask

  initial begin
    int v [1:NB];
    int stall0;
    res = 1'b0; start = 1'b0; hisNum = 1'b0;
    for (int i = 1; i <= NB; i++) hist[i] = 0;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    res = 1'b1;

    v = '{3, 0, 7, 1, 7, 0, 0, 2};
    run_sweep(v, 1'b0, 0, 1'b0);

    v = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_sweep(v, 1'b1, 0, 1'b0);

    stall0 = stall_total;
    v = '{5, 9, 4, 0, 9, 1, 2, 3};
    run_sweep(v, 1'b0, 2, 1'b0);
    chk("backpressure_cycles", stall_total - stall0, 5);

    for (int i = 1; i < NB; i++) v[i] = $urandom_range(0, 254);
    v[NB] = 255;
    run_sweep(v, 1'b1, 0, 1'b0);

    for (int i = 1; i <= NB; i++) v[i] = $urandom_range(0, 255);
    run_sweep(v, 1'b0, 1, 1'b1);

    // Abandon a sweep at bin 4.
    begin
      peak_t p;
      int n;
      v = '{10, 20, 30, 40, 50, 60, 70, 80};
      hist = v;
      rdy_mode = 0; lat_on = 1;
      expect_sweep(v, 1'b1, p);
      pulse_start(1'b1);
      n = 0;
      while (outBin != BW'(4) && n < 100) begin @(negedge clk); n++; end
      chk("reached_bin4", outBin, 4);
      @(posedge clk); #2 res = 1'b0;
      #1 chk_all_zero("midreset");
      bq.delete(); pq.delete();
      n = clr_total;
      repeat (2) @(posedge clk);
      chk("no_clr_in_reset", clr_total - n, 0);
      #1 res = 1'b1;
    end

    v = '{1, 2, 3, 4, 5, 6, 7, 6};
    run_sweep(v, 1'b1, 0, 1'b0);

    for (int s = 0; s < 6; s++) begin
      for (int i = 1; i <= NB; i++)
        v[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
      run_sweep(v, 1'($urandom_range(0, 1)), 1 - (s % 2), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end
endmodule
